reg_file_controller: RTL
========================

# reg_file_controller

Multi-cycle control FSM for the 8-bit datapath built around the 4×8-bit register file. It fetches 8-bit instructions over a req/ack instruction-memory port and decodes them. It then sequences register reads, ALU use, data-memory access and register writeback, including the one-cycle register-file write strobe. It sits between instruction/data memory and the register file/ALU, and owns PC and IR.

## Interface
Parameters:
- RESET_PC, 8'h00, PC value loaded on reset and on START from IDLE/HALT.

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  level; leaves IDLE/HALT and begins fetching at RESET_PC
- INSTR  in  8  instruction word, valid when IMEM_ACK=1
- IMEM_ACK  in  1  instruction-memory acknowledge
- DMEM_ACK  in  1  data-memory acknowledge
- STEP  in  1  single-step advance (present only with CTRL_SINGLE_STEP_EN)
- IMEM_REQ  out  1  fetch request at address PC
- PC  out  8  program counter
- IR  out  8  latched instruction
- Read_Reg1 / Read_Reg2  out  2 each  register-file read selects (IR[5:4] / IR[3:2])
- Write_Reg  out  2  writeback destination
- RegWrite  out  1  write enable to register file
- State_Reg_Write  out  1  one-cycle register-file write strobe
- ALU_Src  out  1  0=Read_Data2, 1=sign-extended IR[1:0]
- DMEM_REQ / DMEM_WE  out  1 each  data-memory request / write
- BUSY  out  1  state ≠ IDLE and ≠ HALT
- HALTED  out  1  state = HALT
- INSTR_COUNT  out  8  retired instructions, wraps 8'hFF→8'h00

## Operation
- ISA: IR[7:6] opcode. 00 ADD: rd=IR[1:0] ← rs+rt. 01 LW: rt ← mem[rs+sext(IR[1:0])]. 10 SW: mem[rs+sext(IR[1:0])] ← rt. 11 J: PC ← PC+1+sext(IR[5:0]). IR=8'hFF (J −1, a self-jump) is HALT.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE --START--> FETCH, PC←RESET_PC. HALT --START--> FETCH, PC←RESET_PC, INSTR_COUNT←0.
- FETCH: IMEM_REQ=1 held until IMEM_ACK is sampled high. On that edge: IR←INSTR, PC←PC+1, go to DECODE.
- DECODE: HALT instruction → HALT, with retire. J → PC←PC+sext(IR[5:0]) (PC is already incremented), retire, go to FETCH. Otherwise → EXEC.
- EXEC: ADD → WB. LW/SW → MEM.
- MEM: DMEM_REQ=1 and DMEM_WE=(SW) held until DMEM_ACK. LW → WB. SW → retire, go to FETCH.
- WB: RegWrite=1 and State_Reg_Write=1 for exactly this one cycle. Write_Reg = IR[1:0] for ADD, IR[3:2] for LW. Retire, go to FETCH.
- Retire: INSTR_COUNT increments by 1, mod 256.
- All PC arithmetic is mod 256 (wraps 8'hFF→8'h00).
- Read_Reg1/2 are driven combinationally from IR in every state.
- ALU_Src=1 for LW/SW, 0 otherwise.

## Timing
- Reset values: state IDLE; PC=RESET_PC; IR=0; INSTR_COUNT=0. All control outputs (IMEM_REQ, DMEM_REQ, DMEM_WE, RegWrite, State_Reg_Write, ALU_Src, BUSY, HALTED) are 0. Write_Reg=0.
- With zero-wait ack, latencies from FETCH entry to return to FETCH: ADD 4 cycles, LW 5, SW 4, J 2.
- Each wait cycle on an ack adds exactly one cycle. An ack outside its request state is ignored.
- State_Reg_Write never asserts outside WB, and is never high on two consecutive cycles.
- RST_N low mid-operation, including during MEM with DMEM_REQ high, drops every output to its reset value immediately (asynchronous). The aborted instruction is not retired.
- START held high in FETCH..WB has no effect.

## Configuration
- CTRL_SINGLE_STEP_EN defined: an extra state WAIT_STEP sits between retire and FETCH. The controller leaves WAIT_STEP on the first cycle STEP=1 (level-sampled). BUSY stays 1 in WAIT_STEP.
- CTRL_SINGLE_STEP_EN undefined: the STEP port is absent and retire goes directly to FETCH.

## Structure
- Shared package ctrl_pkg: opcode constants (OP_ADD, OP_LW, OP_SW, OP_J), HALT_INSTR=8'hFF, the state enum, and a sext2/sext6 helper.
- Sub-module ctrl_decode: purely combinational IR → {is_add, is_lw, is_sw, is_j, is_halt, dest, imm}.
- The top module holds the FSM, PC, IR and the counter.

## Test plan
- Reset then START, INSTR=8'b00_01_10_11 (ADD r3=r1+r2), zero-wait ack → WB in the 4th cycle after FETCH entry, Write_Reg=3, one State_Reg_Write pulse, INSTR_COUNT=1, PC=1.
- LW 8'b01_00_10_11 with DMEM_ACK delayed 3 cycles → DMEM_REQ=1 for 4 cycles, DMEM_WE=0, ALU_Src=1, then WB with Write_Reg=2.
- SW 8'b10_01_00_01 → DMEM_WE=1 during MEM; RegWrite and State_Reg_Write never asserted; returns to FETCH.
- PC=8'hFE, J 8'b11_000011 → PC=8'h02 (wrap). Then 8'hFF → HALTED=1, IMEM_REQ stays 0. Then START → PC=RESET_PC, INSTR_COUNT=0.
- Assert RST_N low during MEM with DMEM_REQ high → all outputs 0 asynchronously, INSTR_COUNT unchanged from reset value 0.
- With CTRL_SINGLE_STEP_EN: after ADD retires, no IMEM_REQ until STEP=1; the next fetch begins the cycle after STEP is sampled.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the register-file controller: opcodes, FSM states
// and immediate sign-extension helpers.
package ctrl_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam logic [7:0] HALT_INSTR = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_WAIT_STEP
  } state_t;

  function automatic logic [7:0] sext2(input logic [1:0] v);
    return {{6{v[1]}}, v};
  endfunction

  function automatic logic [7:0] sext6(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decoder: IR -> instruction class,
// writeback destination and sign-extended immediate.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [7:0] i_ir,
  output logic       o_is_add,
  output logic       o_is_lw,
  output logic       o_is_sw,
  output logic       o_is_j,
  output logic       o_is_halt,
  output logic [1:0] o_dest,
  output logic [7:0] o_imm
);

  logic [1:0] w_op;
  assign w_op = i_ir[7:6];

  always_comb begin
    o_is_halt = (i_ir == HALT_INSTR);
    o_is_add  = (w_op == OP_ADD);
    o_is_lw   = (w_op == OP_LW);
    o_is_sw   = (w_op == OP_SW);
    o_is_j    = (w_op == OP_J) && (i_ir != HALT_INSTR);
    o_dest    = 2'b00;
    if (w_op == OP_ADD)     o_dest = i_ir[1:0];
    else if (w_op == OP_LW) o_dest = i_ir[3:2];
    // Jumps take a 6-bit offset; memory ops take the 2-bit displacement.
    o_imm = (w_op == OP_J) ? sext6(i_ir[5:0]) : sext2(i_ir[1:0]);
  end

endmodule

// File: rtl/reg_file_controller.sv
// Multi-cycle fetch/decode/execute controller owning PC, IR and the retired
// instruction counter. Optional single-step mode: CTRL_SINGLE_STEP_EN.
module reg_file_controller
  import ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [7:0] INSTR,
  input  logic       IMEM_ACK,
  input  logic       DMEM_ACK,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic       STEP,
`endif
  output logic       IMEM_REQ,
  output logic [7:0] PC,
  output logic [7:0] IR,
  output logic [1:0] Read_Reg1,
  output logic [1:0] Read_Reg2,
  output logic [1:0] Write_Reg,
  output logic       RegWrite,
  output logic       State_Reg_Write,
  output logic       ALU_Src,
  output logic       DMEM_REQ,
  output logic       DMEM_WE,
  output logic       BUSY,
  output logic       HALTED,
  output logic [7:0] INSTR_COUNT
);

  localparam state_t ST_AFTER_RETIRE =
`ifdef CTRL_SINGLE_STEP_EN
    ST_WAIT_STEP;
`else
    ST_FETCH;
`endif

  state_t     r_state, w_next;
  logic [7:0] r_pc, r_ir, r_cnt;
  logic       w_is_add, w_is_lw, w_is_sw, w_is_j, w_is_halt;
  logic [1:0] w_dest;
  logic [7:0] w_imm;
  logic       w_load_ir, w_pc_rst, w_pc_jump, w_retire, w_cnt_clr;

  ctrl_decode u_decode (
    .i_ir      (r_ir),
    .o_is_add  (w_is_add),
    .o_is_lw   (w_is_lw),
    .o_is_sw   (w_is_sw),
    .o_is_j    (w_is_j),
    .o_is_halt (w_is_halt),
    .o_dest    (w_dest),
    .o_imm     (w_imm)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    w_load_ir       = 1'b0;
    w_pc_rst        = 1'b0;
    w_pc_jump       = 1'b0;
    w_retire        = 1'b0;
    w_cnt_clr       = 1'b0;
    IMEM_REQ        = 1'b0;
    DMEM_REQ        = 1'b0;
    DMEM_WE         = 1'b0;
    RegWrite        = 1'b0;
    State_Reg_Write = 1'b0;
    Write_Reg       = 2'b00;
    case (r_state)
      ST_IDLE: if (START) begin
        w_next   = ST_FETCH;
        w_pc_rst = 1'b1;
      end
      ST_HALT: if (START) begin
        w_next    = ST_FETCH;
        w_pc_rst  = 1'b1;
        w_cnt_clr = 1'b1;
      end
      ST_FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_ACK) begin
          w_load_ir = 1'b1;
          w_next    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_is_halt) begin
          w_retire = 1'b1;
          w_next   = ST_HALT;
        end else if (w_is_j) begin
          w_pc_jump = 1'b1;
          w_retire  = 1'b1;
          w_next    = ST_AFTER_RETIRE;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: w_next = w_is_add ? ST_WB : ST_MEM;
      ST_MEM: begin
        DMEM_REQ = 1'b1;
        DMEM_WE  = w_is_sw;
        if (DMEM_ACK) begin
          w_retire = w_is_sw;
          w_next   = w_is_sw ? ST_AFTER_RETIRE : ST_WB;
        end
      end
      ST_WB: begin
        RegWrite        = 1'b1;
        State_Reg_Write = 1'b1;
        Write_Reg       = w_dest;
        w_retire        = 1'b1;
        w_next          = ST_AFTER_RETIRE;
      end
`ifdef CTRL_SINGLE_STEP_EN
      ST_WAIT_STEP: if (STEP) w_next = ST_FETCH;
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc  <= RESET_PC;
      r_ir  <= 8'h00;
      r_cnt <= 8'h00;
    end else begin
      // PC already points past the jump when DECODE adds the offset.
      if (w_pc_rst)       r_pc <= RESET_PC;
      else if (w_load_ir) r_pc <= r_pc + 8'd1;
      else if (w_pc_jump) r_pc <= r_pc + w_imm;
      if (w_load_ir) r_ir <= INSTR;
      if (w_cnt_clr)     r_cnt <= 8'h00;
      else if (w_retire) r_cnt <= r_cnt + 8'd1;
    end
  end

  assign PC          = r_pc;
  assign IR          = r_ir;
  assign INSTR_COUNT = r_cnt;
  assign Read_Reg1   = r_ir[5:4];
  assign Read_Reg2   = r_ir[3:2];
  assign ALU_Src     = w_is_lw | w_is_sw;
  assign BUSY        = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign HALTED      = (r_state == ST_HALT);

endmodule
